mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 29 ++
 rtl/mem_arbiter_if.sv | 51 +++++
 rtl/rr_arb_tree_lite.sv | 43 ++++
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_arb_pkg
// Brief  : Shared constants and request-payload types for mem_arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  localparam int unsigned MAX_PORTS      = 8;
  localparam int unsigned DEF_ADDR_WIDTH = 64;
  localparam int unsigned DEF_DATA_WIDTH = 64;

  typedef logic [DEF_ADDR_WIDTH-1:0]   addr_t;
  typedef logic [DEF_DATA_WIDTH-1:0]   data_t;
  typedef logic [DEF_DATA_WIDTH/8-1:0] be_t;

  typedef struct packed {
    logic  we;
    addr_t addr;
    be_t   be;
    data_t wdata;
  } req_payload_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : mem_arbiter_if
// Brief  : Requester-side and SRAM-side bundle of mem_arbiter.
//          lock_i exists only when MEM_ARB_LOCK_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
  parameter int unsigned NR_PORTS   = 2,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64
);

  logic [NR_PORTS-1:0]                   req_i;
  logic [NR_PORTS-1:0]                   gnt_o;
  logic [NR_PORTS-1:0]                   we_i;
  logic [NR_PORTS-1:0][ADDR_WIDTH-1:0]   addr_i;
  logic [NR_PORTS-1:0][DATA_WIDTH/8-1:0] be_i;
  logic [NR_PORTS-1:0][DATA_WIDTH-1:0]   wdata_i;
  logic [NR_PORTS-1:0]                   rvalid_o;
  logic [DATA_WIDTH-1:0]                 rdata_o;
`ifdef MEM_ARB_LOCK_EN
  logic [NR_PORTS-1:0]                   lock_i;
`endif
  logic                                  mem_req_o;
  logic                                  mem_we_o;
  logic [ADDR_WIDTH-1:0]                 mem_addr_o;
  logic [DATA_WIDTH/8-1:0]               mem_be_o;
  logic [DATA_WIDTH-1:0]                 mem_wdata_o;
  logic [DATA_WIDTH-1:0]                 mem_rdata_i;

  modport slave (
`ifdef MEM_ARB_LOCK_EN
    input  lock_i,
`endif
    input  req_i, we_i, addr_i, be_i, wdata_i, mem_rdata_i,
    output gnt_o, rvalid_o, rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
  );

  modport master (
`ifdef MEM_ARB_LOCK_EN
    output lock_i,
`endif
    output req_i, we_i, addr_i, be_i, wdata_i, mem_rdata_i,
    input  gnt_o, rvalid_o, rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
  );

endinterface
`default_nettype wire

// File: rtl/rr_arb_tree_lite.sv
`default_nettype none
// ============================================================================
// Module : rr_arb_tree_lite
// Brief  : Combinational round-robin picker: first request at or above ptr_i.
// Rev    : 1.0 - initial release
// ============================================================================
module rr_arb_tree_lite #(
  parameter int unsigned NR_PORTS = 2,
  parameter int unsigned IDX_W    = 1
) (
  input  wire logic [NR_PORTS-1:0] req_i,
  input  wire logic [IDX_W-1:0]    ptr_i,
  output logic      [NR_PORTS-1:0] gnt_o,
  output logic      [IDX_W-1:0]    idx_o,
  output logic                     valid_o
);

  localparam logic [IDX_W:0] N_W = (IDX_W+1)'(NR_PORTS);

  logic [NR_PORTS-1:0] req_rot;
  logic [IDX_W-1:0]    off;
  logic [IDX_W:0]      sum;

  // Rotating the doubled vector puts the pointer position at bit 0.
  assign req_rot = NR_PORTS'({req_i, req_i} >> ptr_i);

  always_comb begin
    off     = '0;
    valid_o = 1'b0;
    for (int k = int'(NR_PORTS) - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        off     = IDX_W'(k);
        valid_o = 1'b1;
      end
    end
  end

  assign sum   = {1'b0, ptr_i} + {1'b0, off};
  assign idx_o = (sum >= N_W) ? IDX_W'(sum - N_W) : IDX_W'(sum);
  assign gnt_o = valid_o ? (NR_PORTS'(1) << idx_o) : '0;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_arbiter
// Brief  : Round-robin arbiter sharing one single-cycle SRAM port between
//          NR_PORTS requesters. Define MEM_ARB_LOCK_EN for grant locking.
// Rev    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NR_PORTS   = 2,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64
) (
  input wire logic   clk_i,
  input wire logic   rst_ni,
  mem_arbiter_if.slave bus
);

  localparam int unsigned      IDX_W    = idx_width(NR_PORTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_PORTS - 1);

  if ((NR_PORTS < 2) || (NR_PORTS > MAX_PORTS)) begin : g_bad_nr_ports
    $error("mem_arbiter: NR_PORTS out of range");
  end

  logic [IDX_W-1:0]    rr_q, rr_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [IDX_W-1:0]    rsp_idx_q, rsp_idx_d;
  logic [NR_PORTS-1:0] req_elig;
  logic [NR_PORTS-1:0] gnt_oh;
  logic [IDX_W-1:0]    gnt_idx;
  logic                gnt_valid;
  logic                rr_hold;

`ifdef MEM_ARB_LOCK_EN
  logic             owner_valid_q, owner_valid_d;
  logic [IDX_W-1:0] owner_idx_q, owner_idx_d;

  // An active owner masks every other requester out of arbitration.
  always_comb begin
    req_elig = bus.req_i & {NR_PORTS{rst_ni}};
    if (owner_valid_q) begin
      req_elig = req_elig & (NR_PORTS'(1) << owner_idx_q);
    end
  end

  assign rr_hold = owner_valid_q;

  always_comb begin
    owner_valid_d = owner_valid_q;
    owner_idx_d   = owner_idx_q;
    if (owner_valid_q) begin
      if (!bus.lock_i[owner_idx_q]) begin
        owner_valid_d = 1'b0;
      end
    end else if (gnt_valid && bus.lock_i[gnt_idx]) begin
      owner_valid_d = 1'b1;
      owner_idx_d   = gnt_idx;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_valid_q <= 1'b0;
      owner_idx_q   <= '0;
    end else begin
      owner_valid_q <= owner_valid_d;
      owner_idx_q   <= owner_idx_d;
    end
  end
`else
  assign req_elig = bus.req_i & {NR_PORTS{rst_ni}};
  assign rr_hold  = 1'b0;
`endif

  rr_arb_tree_lite #(
    .NR_PORTS (NR_PORTS),
    .IDX_W    (IDX_W)
  ) u_picker (
    .req_i   (req_elig),
    .ptr_i   (rr_q),
    .gnt_o   (gnt_oh),
    .idx_o   (gnt_idx),
    .valid_o (gnt_valid)
  );

  assign bus.gnt_o = gnt_oh;

  always_comb begin
    bus.mem_req_o   = gnt_valid;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_be_o    = '0;
    bus.mem_wdata_o = '0;
    if (gnt_valid) begin
      bus.mem_we_o    = bus.we_i[gnt_idx];
      bus.mem_addr_o  = bus.addr_i[gnt_idx];
      bus.mem_be_o    = bus.be_i[gnt_idx];
      bus.mem_wdata_o = bus.wdata_i[gnt_idx];
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (gnt_valid && !rr_hold) begin
      rr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
    end
  end

  // SRAM returns read data one cycle later; remember who asked.
  assign rsp_valid_d = gnt_valid & ~bus.we_i[gnt_idx];
  assign rsp_idx_d   = gnt_idx;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_idx_q   <= '0;
    end else begin
      rr_q        <= rr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_idx_q   <= rsp_idx_d;
    end
  end

  assign bus.rvalid_o = rsp_valid_q ? (NR_PORTS'(1) << rsp_idx_q) : '0;
  assign bus.rdata_o  = bus.mem_rdata_i;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_arbiter
// Brief  : Self-checking bench for mem_arbiter with a behavioural model.
//          Lock scenarios run when MEM_ARB_LOCK_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned NP = 4;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_arbiter_if #(.NR_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_arbiter #(.NR_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  logic [DW-1:0] mem_rdata_q = '0;
  always @(posedge clk) mem_rdata_q <= {$urandom, $urandom};
  assign bus.mem_rdata_i = mem_rdata_q;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Requester state: each port holds its payload until the model grants it.
  req_payload_t pay  [NP];
  bit           pend [NP];
`ifdef MEM_ARB_LOCK_EN
  logic [NP-1:0] lock_v = '0;
`endif

  // Reference model state.
  int m_rr        = 0;
  int m_owner     = -1;
  int m_rsp_port  = 0;
  bit m_rsp_valid = 1'b0;

  logic [NP-1:0] o_gnt, o_rvalid;
  logic          o_mreq, o_mwe;
  logic [AW-1:0] o_maddr;

  task automatic run_cycle();
    int            win;
    int            best_d;
    int            d;
    logic [NP-1:0] e_gnt;
    logic [NP-1:0] e_rv;
    for (int p = 0; p < int'(NP); p++) begin
      bus.req_i[p]   = pend[p];
      bus.we_i[p]    = pay[p].we;
      bus.addr_i[p]  = pay[p].addr;
      bus.be_i[p]    = pay[p].be;
      bus.wdata_i[p] = pay[p].wdata;
    end
`ifdef MEM_ARB_LOCK_EN
    bus.lock_i = lock_v;
`endif
    @(negedge clk);
    if (!rst_n) begin
      m_rr        = 0;
      m_owner     = -1;
      m_rsp_valid = 1'b0;
    end
    win    = -1;
    best_d = NP;
    if (rst_n) begin
      for (int p = 0; p < int'(NP); p++) begin
        d = (p - m_rr + int'(NP)) % int'(NP);
        if (pend[p] && (m_owner < 0 || m_owner == p) && d < best_d) begin
          win    = p;
          best_d = d;
        end
      end
    end
    e_gnt = (win >= 0) ? (NP'(1) << win) : '0;
    e_rv  = m_rsp_valid ? (NP'(1) << m_rsp_port) : '0;

    o_gnt    = bus.gnt_o;
    o_rvalid = bus.rvalid_o;
    o_mreq   = bus.mem_req_o;
    o_mwe    = bus.mem_we_o;
    o_maddr  = bus.mem_addr_o;

    check_eq("gnt",      64'(o_gnt),    64'(e_gnt));
    check_eq("rvalid",   64'(o_rvalid), 64'(e_rv));
    check_eq("mem_req",  64'(o_mreq),   64'(win >= 0));
    check_eq("mem_we",   64'(o_mwe),    (win >= 0) ? 64'(pay[win].we)    : 64'd0);
    check_eq("mem_addr", o_maddr,       (win >= 0) ? pay[win].addr       : 64'd0);
    check_eq("mem_be",   64'(bus.mem_be_o),    (win >= 0) ? 64'(pay[win].be) : 64'd0);
    check_eq("mem_wdata", bus.mem_wdata_o,     (win >= 0) ? pay[win].wdata   : 64'd0);
    check_eq("rdata",    bus.rdata_o,   mem_rdata_q);

    if (rst_n) begin
      m_rsp_valid = (win >= 0) && !pay[win].we;
      m_rsp_port  = (win >= 0) ? win : 0;
      if (win >= 0 && m_owner < 0) m_rr = (win + 1) % int'(NP);
`ifdef MEM_ARB_LOCK_EN
      if (m_owner >= 0) begin
        if (!lock_v[m_owner]) m_owner = -1;
      end else if (win >= 0 && lock_v[win]) begin
        m_owner = win;
      end
`endif
      if (win >= 0) pend[win] = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input bit we, input logic [63:0] addr,
                         input logic [7:0] be, input logic [63:0] wdata);
    pend[p]      = 1'b1;
    pay[p].we    = we;
    pay[p].addr  = addr;
    pay[p].be    = be;
    pay[p].wdata = wdata;
  endtask

  task automatic do_reset();
    for (int p = 0; p < int'(NP); p++) pend[p] = 1'b0;
    rst_n = 1'b0;
    run_cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int p = 0; p < int'(NP); p++) set_req(p, 1'b0, 64'(p * 8), 8'hFF, 64'(p));
    rst_n = 1'b0;
    #1;
    run_cycle();
    check_eq("reset_gnt", 64'(o_gnt), 64'd0);
    check_eq("reset_mem_req", 64'(o_mreq), 64'd0);
    do_reset();

    // Two readers from rr=0.
    set_req(0, 1'b0, 64'h100, 8'hFF, 64'd0);
    set_req(1, 1'b0, 64'h108, 8'hFF, 64'd0);
    run_cycle();
    check_eq("rd2_c0_gnt", 64'(o_gnt), 64'b0001);
    run_cycle();
    check_eq("rd2_c1_gnt", 64'(o_gnt), 64'b0010);
    check_eq("rd2_c1_rvalid", 64'(o_rvalid), 64'b0001);
    run_cycle();
    check_eq("rd2_c2_rvalid", 64'(o_rvalid), 64'b0010);

    // Lone writer on port 1.
    set_req(1, 1'b1, 64'h40, 8'hFF, 64'hDEAD);
    run_cycle();
    check_eq("wr_gnt", 64'(o_gnt), 64'b0010);
    check_eq("wr_mem_req", 64'(o_mreq), 64'd1);
    check_eq("wr_mem_we", 64'(o_mwe), 64'd1);
    check_eq("wr_mem_addr", o_maddr, 64'h40);
    run_cycle();
    check_eq("wr_no_rvalid", 64'(o_rvalid), 64'd0);

    // All four ports requesting continuously.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      for (int p = 0; p < int'(NP); p++) set_req(p, 1'b0, 64'(p), 8'h0F, 64'd0);
      run_cycle();
      check_eq("rr_order", 64'(o_gnt), 64'(NP'(1) << (i % int'(NP))));
    end
    run_cycle();

    // Reset while a read is outstanding.
    do_reset();
    set_req(0, 1'b0, 64'h200, 8'hFF, 64'd0);
    run_cycle();
    check_eq("rst_rd_gnt", 64'(o_gnt), 64'b0001);
    rst_n = 1'b0;
    run_cycle();
    check_eq("rst_rd_rvalid_in", 64'(o_rvalid), 64'd0);
    rst_n = 1'b1;
    run_cycle();
    check_eq("rst_rd_rvalid_after", 64'(o_rvalid), 64'd0);
    for (int p = 0; p < int'(NP); p++) set_req(p, 1'b1, 64'd0, 8'h01, 64'd0);
    run_cycle();
    check_eq("rst_rr_zero", 64'(o_gnt), 64'b0001);

`ifdef MEM_ARB_LOCK_EN
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_req(0, 1'b0, 64'(i), 8'hFF, 64'd0);
      set_req(1, 1'b0, 64'h80, 8'hFF, 64'd0);
      lock_v[0] = 1'b1;
      run_cycle();
      check_eq("lock_hold", 64'(o_gnt), 64'b0001);
    end
    set_req(0, 1'b0, 64'h3, 8'hFF, 64'd0);
    lock_v[0] = 1'b0;
    run_cycle();
    check_eq("lock_release", 64'(o_gnt), 64'b0001);
    run_cycle();
    check_eq("lock_after", 64'(o_gnt), 64'b0010);
`endif

    // Randomised traffic against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < int'(NP); p++) begin
        if (!pend[p] && $urandom_range(1, 0) == 1) begin
          set_req(p, 1'($urandom), {$urandom, $urandom}, 8'($urandom), {$urandom, $urandom});
        end
      end
`ifdef MEM_ARB_LOCK_EN
      for (int p = 0; p < int'(NP); p++) lock_v[p] = ($urandom_range(3, 0) == 0);
`endif
      rst_n = ($urandom_range(63, 0) != 0);
      run_cycle();
      rst_n = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
